// File: rtl/io_peripheral_bank.sv
// Memory-mapped I/O responder: synchronizes and debounces board SW/KEY, keeps sticky key-press
// flags, and holds the LEDR/LEDG/HEX registers feeding four active-low 7-segment digits.
// Latency: rdData is combinational; stores land on the next edge; KEY -> key_db takes 2 + DEBOUNCE_CYCLES edges.
// Backpressure: none. Every strobe is accepted in the cycle it is presented.
//
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   swEn, keyEn          load strobes (SW / KEY registers); keyEn also clears the press flags at the edge
//   ledrEn, ledgEn, hexEn store strobes for LEDR / LEDG / HEX registers
//   wrData[31:0]         store data
//   SW[9:0], KEY[3:0]    raw board inputs, asynchronous to clk (KEY active-low)
//   rdData[31:0]         combinational load data
//   LEDR[9:0], LEDG[7:0] LED registers
//   HEX0..HEX3[6:0]      active-low segments {g,f,e,d,c,b,a} for hex_reg nibbles 0..3
module io_peripheral_bank #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        swEn,
  input  logic        keyEn,
  input  logic        ledrEn,
  input  logic        ledgEn,
  input  logic        hexEn,
  input  logic [31:0] wrData,
  input  logic [9:0]  SW,
  input  logic [3:0]  KEY,
  output logic [31:0] rdData,
  output logic [9:0]  LEDR,
  output logic [7:0]  LEDG,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchronizers. KEY is inverted on entry so that 1 means "pressed" everywhere inside.
  logic [9:0] sw_meta_q, sw_meta_d;
  logic [9:0] sw_s_q, sw_s_d;
  logic [3:0] key_meta_q, key_meta_d;
  logic [3:0] key_s_q, key_s_d;

  // Debounce state and sticky press flags.
  logic [3:0]            key_db_q, key_db_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            flag_q, flag_d;
  logic [3:0]            key_rise;

  // Output registers.
  logic [9:0]  ledr_q, ledr_d;
  logic [7:0]  ledg_q, ledg_d;
  logic [15:0] hex_q, hex_d;

  // Upper store-data bits have no destination register.
  logic unused_wr_hi;
  assign unused_wr_hi = ^wrData[31:16];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    sw_meta_d  = SW;
    sw_s_d     = sw_meta_q;
    key_meta_d = ~KEY;
    key_s_d    = key_meta_q;

    key_db_d = key_db_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (key_s_q[i] == key_db_q[i]) begin
        // Level agrees with the accepted state: any partial count (a bounce) is discarded.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        key_db_d[i] = key_s_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end

    // A press accepted on this edge sets its flag on this same edge, overriding a concurrent
    // read-clear so the press is never lost between the read and the clear.
    key_rise = key_db_d & ~key_db_q;
    flag_d   = (keyEn ? 4'b0000 : flag_q) | key_rise;

    ledr_d = ledrEn ? wrData[9:0]  : ledr_q;
    ledg_d = ledgEn ? wrData[7:0]  : ledg_q;
    hex_d  = hexEn  ? wrData[15:0] : hex_q;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
      key_meta_q <= '0;
      key_s_q    <= '0;
      key_db_q   <= '0;
      cnt_q      <= '0;
      flag_q     <= '0;
      ledr_q     <= '0;
      ledg_q     <= '0;
      hex_q      <= '0;
    end else begin
      sw_meta_q  <= sw_meta_d;
      sw_s_q     <= sw_s_d;
      key_meta_q <= key_meta_d;
      key_s_q    <= key_s_d;
      key_db_q   <= key_db_d;
      cnt_q      <= cnt_d;
      flag_q     <= flag_d;
      ledr_q     <= ledr_d;
      ledg_q     <= ledg_d;
      hex_q      <= hex_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Load-data mux: combinational so it lines up with the decoder's select in the
  // same cycle. Flags shown are the pre-clear values.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdData = 32'b0;
    if (keyEn) begin
      rdData = {24'b0, flag_q, key_db_q};
    end else if (swEn) begin
      rdData = {22'b0, sw_s_q};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign LEDR = ledr_q;
  assign LEDG = ledg_q;
  assign HEX0 = seg7(hex_q[3:0]);
  assign HEX1 = seg7(hex_q[7:4]);
  assign HEX2 = seg7(hex_q[11:8]);
  assign HEX3 = seg7(hex_q[15:12]);

endmodule

// File: tb/tb_io_peripheral_bank.sv
// Directed testbench for io_peripheral_bank with DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Load strobes are "peeked" (raised and dropped within one cycle) so reads do not clear flags.
module tb_io_peripheral_bank;

  logic        clk;
  logic        reset;
  logic        swEn, keyEn, ledrEn, ledgEn, hexEn;
  logic [31:0] wrData;
  logic [9:0]  SW;
  logic [3:0]  KEY;
  logic [31:0] rdData;
  logic [9:0]  LEDR;
  logic [7:0]  LEDG;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;

  int vectors;
  int miscompares;

  io_peripheral_bank #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .swEn(swEn), .keyEn(keyEn), .ledrEn(ledrEn), .ledgEn(ledgEn), .hexEn(hexEn),
    .wrData(wrData), .SW(SW), .KEY(KEY),
    .rdData(rdData), .LEDR(LEDR), .LEDG(LEDG),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Combinational KEY read with no clock edge in between, so flags are untouched.
  task automatic peek_key(input string tag, input logic [31:0] exp);
    keyEn = 1'b1;
    #1;
    check(tag, rdData, exp);
    keyEn = 1'b0;
  endtask

  task automatic peek_sw(input string tag, input logic [31:0] exp);
    swEn = 1'b1;
    #1;
    check(tag, rdData, exp);
    swEn = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b1;
    swEn   = 1'b0; keyEn = 1'b0; ledrEn = 1'b0; ledgEn = 1'b0; hexEn = 1'b0;
    wrData = 32'h0;
    SW     = 10'h000;
    KEY    = 4'hF;

    // ---- reset state ----
    step(3);
    check("rst_hex0", {25'b0, HEX0}, 32'h40);
    check("rst_hex3", {25'b0, HEX3}, 32'h40);
    peek_key("rst_key_rd", 32'h0);
    reset = 1'b0;
    step(3);
    peek_sw("idle_sw_rd", 32'h0);
    peek_key("idle_key_rd", 32'h0);
    check("idle_ledr", {22'b0, LEDR}, 32'h0);
    check("idle_ledg", {24'b0, LEDG}, 32'h0);
    check("idle_hex1", {25'b0, HEX1}, 32'h40);
    check("idle_hex2", {25'b0, HEX2}, 32'h40);

    // ---- KEY[0] press: accepted exactly 6 edges later ----
    KEY = 4'hE;
    step(5);
    peek_key("key0_edge5", 32'h00);
    step(1);
    peek_key("key0_edge6", 32'h11);
    // Real read: shows pre-clear flags, then the flag is gone.
    keyEn = 1'b1;
    #1;
    check("key0_read1", rdData, 32'h11);
    step(1);
    keyEn = 1'b0;
    peek_key("key0_read2", 32'h01);

    // ---- KEY[1] bounce of 2 cycles: ignored ----
    KEY = 4'hC;
    step(2);
    KEY = 4'hE;
    step(10);
    peek_key("key1_bounce", 32'h01);

    // ---- flag set on the same edge as a clearing read ----
    KEY = 4'hA;
    step(5);
    keyEn = 1'b1;
    #1;
    check("key2_pre_set", rdData, 32'h01);
    step(1);
    keyEn = 1'b0;
    peek_key("key2_set_wins", 32'h45);
    keyEn = 1'b1;
    step(1);
    keyEn = 1'b0;
    peek_key("key2_cleared", 32'h05);

    // ---- HEX writes ----
    wrData = 32'h0000BEEF;
    hexEn  = 1'b1;
    step(1);
    hexEn  = 1'b0;
    check("beef_hex3", {25'b0, HEX3}, 32'h03);
    check("beef_hex2", {25'b0, HEX2}, 32'h06);
    check("beef_hex1", {25'b0, HEX1}, 32'h06);
    check("beef_hex0", {25'b0, HEX0}, 32'h0E);
    wrData = 32'h00001234;
    step(1);
    check("hex_hold", {25'b0, HEX0}, 32'h0E);
    wrData = 32'hFFFF7A50;
    hexEn  = 1'b1;
    step(1);
    hexEn  = 1'b0;
    check("7a50_hex0", {25'b0, HEX0}, 32'h40);
    check("7a50_hex1", {25'b0, HEX1}, 32'h12);
    check("7a50_hex2", {25'b0, HEX2}, 32'h08);
    check("7a50_hex3", {25'b0, HEX3}, 32'h78);

    // ---- LED writes ----
    wrData = 32'h000003FF;
    ledrEn = 1'b1;
    ledgEn = 1'b1;
    step(1);
    ledrEn = 1'b0;
    ledgEn = 1'b0;
    check("both_ledr", {22'b0, LEDR}, 32'h3FF);
    check("both_ledg", {24'b0, LEDG}, 32'hFF);
    wrData = 32'h000000A5;
    ledgEn = 1'b1;
    step(1);
    ledgEn = 1'b0;
    check("ledg_only", {24'b0, LEDG}, 32'hA5);
    check("ledr_hold", {22'b0, LEDR}, 32'h3FF);
    check("hex_untouched", {25'b0, HEX0}, 32'h40);

    // ---- SW sync: visible two edges later; keyEn has priority ----
    SW = 10'h2A5;
    step(1);
    peek_sw("sw_edge1", 32'h0);
    step(1);
    peek_sw("sw_edge2", 32'h2A5);
    swEn  = 1'b1;
    keyEn = 1'b1;
    #1;
    check("key_over_sw", rdData, 32'h05);
    swEn  = 1'b0;
    keyEn = 1'b0;
    #1;
    check("no_sel_rd", rdData, 32'h0);

    // ---- reset during a debounce count ----
    KEY = 4'h2;
    step(3);
    reset = 1'b1;
    #1;
    check("mid_rst_ledr", {22'b0, LEDR}, 32'h0);
    check("mid_rst_ledg", {24'b0, LEDG}, 32'h0);
    check("mid_rst_hex2", {25'b0, HEX2}, 32'h40);
    peek_key("mid_rst_key", 32'h0);
    peek_sw("mid_rst_sw", 32'h0);
    KEY = 4'hF;
    step(2);
    reset = 1'b0;
    step(10);
    peek_key("post_rst_key", 32'h0);
    peek_sw("post_rst_sw", 32'h2A5);
    check("post_rst_hex0", {25'b0, HEX0}, 32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
